// File: rtl/sm_mcu_lcd_data_in.sv
// Avalon-MM slave that runs 8080-style read cycles on the LCD bus and captures the 16-bit word.
// Optional VALID/OVERRUN interrupt with IRQ_MASK register: define SM_MCU_LCD_DATA_IN_IRQ_EN.
module sm_mcu_lcd_data_in #(
    parameter int RD_LOW_CYCLES  = 4,
    parameter int RD_HIGH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic        read_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic [15:0] lcd_data_in,
    output logic        lcd_cs_n,
    output logic        lcd_rs,
    output logic        lcd_rd_n,
    output logic        lcd_bus_release,
    output logic        irq
);
    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_RECOVER} state_t;

    localparam logic [7:0] LOW_LD  = 8'(RD_LOW_CYCLES - 1);
    localparam logic [7:0] HIGH_LD = 8'(RD_HIGH_CYCLES - 1);

    state_t      state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic        capture;
    logic        start, rd_data, ovr_clr, ovr_set;
    logic [15:0] data_q;
    logic        valid, overrun, busy;

    assign busy    = (state != S_IDLE);
    assign start   = chipselect & ~write_n & (address == 2'd1) & writedata[0] & ~busy;
    assign rd_data = chipselect & ~read_n & (address == 2'd0);
    assign ovr_clr = chipselect & ~write_n & (address == 2'd2) & writedata[2];
    // A DATA read on the capture edge consumes the old word, so it is not an overrun.
    assign ovr_set = capture & valid & ~rd_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_SETUP;
                    cnt_nxt   = 8'd0;
                end
            end
            S_SETUP: begin
                state_nxt = S_STROBE;
                cnt_nxt   = LOW_LD;
            end
            S_STROBE: begin
                if (cnt == 8'd0) begin
                    state_nxt = S_RECOVER;
                    cnt_nxt   = HIGH_LD;
                    capture   = 1'b1;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            S_RECOVER: begin
                if (cnt == 8'd0) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = 8'd0;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Pins are decoded from the next state so they come straight off flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lcd_cs_n        <= 1'b1;
            lcd_rd_n        <= 1'b1;
            lcd_rs          <= 1'b0;
            lcd_bus_release <= 1'b0;
        end else begin
            lcd_cs_n        <= (state_nxt == S_IDLE);
            lcd_rd_n        <= (state_nxt != S_STROBE);
            lcd_bus_release <= (state_nxt != S_IDLE);
            if (start)
                lcd_rs <= writedata[1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= 16'd0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (capture)
                data_q <= lcd_data_in;
            if (capture)
                valid <= 1'b1;
            else if (rd_data)
                valid <= 1'b0;
            if (ovr_set)
                overrun <= 1'b1;
            else if (ovr_clr)
                overrun <= 1'b0;
        end
    end

`ifdef SM_MCU_LCD_DATA_IN_IRQ_EN
    logic [1:0] irq_mask;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask <= 2'b00;
            irq      <= 1'b0;
        end else begin
            if (chipselect & ~write_n & (address == 2'd3))
                irq_mask <= writedata[1:0];
            irq <= (irq_mask[0] & valid) | (irq_mask[1] & overrun);
        end
    end
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        readdata = 32'd0;
        case (address)
            2'd0: readdata = {16'd0, data_q};
            2'd2: readdata = {29'd0, overrun, valid, busy};
`ifdef SM_MCU_LCD_DATA_IN_IRQ_EN
            2'd3: readdata = {30'd0, irq_mask};
`endif
            default: readdata = 32'd0;
        endcase
    end

    logic unused_wd;
    assign unused_wd = ^writedata[31:3];

endmodule

// File: tb/tb_sm_mcu_lcd_data_in.sv
// Directed bench for sm_mcu_lcd_data_in with default strobe timing (4 low, 2 recovery).
module tb_sm_mcu_lcd_data_in;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic        read_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [15:0] lcd_data_in = 16'd0;
    logic        lcd_cs_n, lcd_rs, lcd_rd_n, lcd_bus_release, irq;

    int checks = 0;
    int errors = 0;

`ifdef SM_MCU_LCD_DATA_IN_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    sm_mcu_lcd_data_in dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(readdata),
        .lcd_data_in(lcd_data_in), .lcd_cs_n(lcd_cs_n), .lcd_rs(lcd_rs),
        .lcd_rd_n(lcd_rd_n), .lcd_bus_release(lcd_bus_release), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic peek(input string tag, input logic [1:0] a, input logic [31:0] exp);
        address = a;
        #1 chk(tag, readdata, exp);
    endtask

    task automatic rd_data(input string tag, input logic [31:0] exp);
        @(negedge clk);
        address = 2'd0; chipselect = 1'b1; read_n = 1'b0;
        #1 chk(tag, readdata, exp);
        @(negedge clk);
        chipselect = 1'b0; read_n = 1'b1;
    endtask

    initial begin
        int low, busy_n, irq_n, rs_bad, first_low, first_valid;

        // Reset state
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        peek("rst_a0", 2'd0, 32'h0);
        peek("rst_a1", 2'd1, 32'h0);
        peek("rst_a2", 2'd2, 32'h0);
        peek("rst_a3", 2'd3, 32'h0);
        chk("rst_pins", {28'd0, lcd_cs_n, lcd_rd_n, lcd_rs, lcd_bus_release}, 32'hC);
        chk("rst_irq", {31'd0, irq}, 32'h0);

        wr(2'd3, 32'h1);
        peek("mask_rb", 2'd3, IRQ_ON ? 32'h1 : 32'h0);

        // Basic read cycle, rs=1
        lcd_data_in = 16'hA5C3;
        wr(2'd1, 32'h3);
        address = 2'd2;
        low = 0; busy_n = 0; irq_n = 0; first_low = -1; first_valid = -1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (i == 0) chk("setup_rs", {31'd0, lcd_rs}, 32'h1);
            if (i == 0) chk("setup_cs", {30'd0, lcd_cs_n, lcd_bus_release}, 32'h1);
            if (!lcd_rd_n) begin low++; if (first_low < 0) first_low = i; end
            if (readdata[0]) busy_n++;
            if (readdata[1] && first_valid < 0) first_valid = i;
            if (irq) irq_n++;
            @(negedge clk);
        end
        chk("rd_low_cycles", low, 32'd4);
        chk("rd_first_low", first_low, 32'd1);
        chk("busy_cycles", busy_n, 32'd7);
        chk("valid_edge", first_valid, 32'd5);
        chk("irq_cycles", irq_n, IRQ_ON ? 32'd4 : 32'd0);
        peek("data1", 2'd0, 32'h0000A5C3);
        peek("stat1", 2'd2, 32'h2);
        rd_data("rd1", 32'h0000A5C3);
        peek("stat1_clr", 2'd2, 32'h0);
        @(negedge clk);
        chk("irq_after_rd", {31'd0, irq}, 32'h0);

        // Overrun
        lcd_data_in = 16'h1111;
        wr(2'd1, 32'h1);
        repeat (8) @(negedge clk);
        lcd_data_in = 16'h2222;
        wr(2'd1, 32'h1);
        repeat (8) @(negedge clk);
        peek("data_ovr", 2'd0, 32'h2222);
        peek("stat_ovr", 2'd2, 32'h6);
        chk("rs_zero", {31'd0, lcd_rs}, 32'h0);
        wr(2'd2, 32'h4);
        peek("stat_ovr_clr", 2'd2, 32'h2);
        rd_data("rd_ovr", 32'h2222);
        peek("stat_ovr_rd", 2'd2, 32'h0);

        // CTRL writes while busy (mid-strobe and on the return-to-idle edge) are ignored
        lcd_data_in = 16'h3C3C;
        wr(2'd1, 32'h3);
        low = 0; rs_bad = 0;
        for (int i = 0; i < 14; i++) begin
            if (!lcd_rd_n) low++;
            if (lcd_rs !== 1'b1) rs_bad++;
            if (i == 1 || i == 6) begin
                address = 2'd1; writedata = 32'h1; chipselect = 1'b1; write_n = 1'b0;
            end else begin
                chipselect = 1'b0; write_n = 1'b1;
            end
            @(negedge clk);
        end
        chk("busy_ign_low", low, 32'd4);
        chk("busy_ign_rs", rs_bad, 32'd0);
        chk("busy_ign_cs", {31'd0, lcd_cs_n}, 32'h1);
        peek("busy_ign_stat", 2'd2, 32'h2);
        peek("busy_ign_data", 2'd0, 32'h3C3C);

        // DATA read coinciding with capture: old word returned, no overrun
        lcd_data_in = 16'h7E7E;
        wr(2'd1, 32'h1);
        repeat (4) @(negedge clk);
        address = 2'd0; chipselect = 1'b1; read_n = 1'b0;
        #1 chk("coin_rd_old", readdata, 32'h3C3C);
        @(negedge clk);
        chipselect = 1'b0; read_n = 1'b1;
        peek("coin_stat", 2'd2, 32'h3);
        repeat (3) @(negedge clk);
        peek("coin_data", 2'd0, 32'h7E7E);

        // OVERRUN clear and set on the same edge: set wins
        lcd_data_in = 16'h0F0F;
        wr(2'd1, 32'h1);
        repeat (4) @(negedge clk);
        address = 2'd2; writedata = 32'h4; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
        #1 chk("set_wins", readdata, 32'h7);
        repeat (3) @(negedge clk);
        wr(2'd2, 32'h4);
        peek("set_wins_clr", 2'd2, 32'h2);
        rd_data("rd_0f", 32'h0F0F);

        // Async reset mid-strobe
        lcd_data_in = 16'h5555;
        wr(2'd1, 32'h3);
        @(negedge clk);
        chk("pre_rst_rd", {31'd0, lcd_rd_n}, 32'h0);
        reset_n = 1'b0;
        #1;
        chk("arst_pins", {28'd0, lcd_cs_n, lcd_rd_n, lcd_rs, lcd_bus_release}, 32'hC);
        peek("arst_stat", 2'd2, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        low = 0;
        for (int i = 0; i < 8; i++) begin
            if (!lcd_rd_n) low++;
            @(negedge clk);
        end
        chk("arst_no_strobe", low, 32'd0);
        peek("arst_data", 2'd0, 32'h0);
        peek("arst_stat2", 2'd2, 32'h0);
        peek("arst_mask", 2'd3, 32'h0);
        chk("arst_irq", {31'd0, irq}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
